// File: rtl/wide_split.sv
// Wide-to-narrow byte unpacker: 64-bit words enter a byte FIFO and are drained
// onto a 32-bit lane-strobed interface, with the consumer picking lanes every cycle.
module wide_split #(
    parameter int DEPTH_BYTES = 16,
    localparam int CW = $clog2(DEPTH_BYTES) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [63:0]   i_data,
    input  logic          i_vld,
    output logic          o_rdy,
    input  logic [3:0]    i_rd_strobe,
    output logic [31:0]   o_data,
    output logic [3:0]    o_strobe,
    output logic          o_vld,
    output logic [CW-1:0] o_cnt
);

    // mem[0] is always the oldest byte; pops shift the queue down.
    logic [7:0]    mem      [DEPTH_BYTES];
    logic [7:0]    mem_next [DEPTH_BYTES];
    logic [CW-1:0] cnt, cnt_next, popped, base;
    logic [31:0]   beat_data;
    logic [3:0]    beat_strb;
    logic          push;

    assign o_rdy = rst_n && (cnt <= CW'(DEPTH_BYTES - 8));
    assign o_cnt = cnt;
    assign push  = i_vld && o_rdy;

    always_comb begin
        popped    = '0;
        beat_data = '0;
        beat_strb = '0;
        // Highest requested lane takes the oldest byte; stop once cnt is exhausted.
        for (int l = 3; l >= 0; l--) begin
            if (i_rd_strobe[l] && popped < cnt) begin
                beat_data[8*l +: 8] = mem[popped[CW-2:0]];
                beat_strb[l]        = 1'b1;
                popped              = popped + CW'(1);
            end
        end

        base = cnt - popped;
        for (int j = 0; j < DEPTH_BYTES; j++) begin
            mem_next[j] = 8'h00;
            for (int p = 0; p <= 4; p++) begin
                if (popped == CW'(p) && j + p < DEPTH_BYTES)
                    mem_next[j] = mem[j+p];
            end
            // The new word lands right behind whatever survives this cycle's pop.
            for (int b = 0; b < 8; b++) begin
                if (push && j >= b && base == CW'(j - b))
                    mem_next[j] = i_data[8*(7-b) +: 8];
            end
        end

        cnt_next = base + (push ? CW'(8) : CW'(0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            o_data   <= '0;
            o_strobe <= '0;
            o_vld    <= 1'b0;
            for (int j = 0; j < DEPTH_BYTES; j++) mem[j] <= 8'h00;
        end else begin
            cnt      <= cnt_next;
            o_data   <= beat_data;
            o_strobe <= beat_strb;
            o_vld    <= |beat_strb;
            for (int j = 0; j < DEPTH_BYTES; j++) mem[j] <= mem_next[j];
        end
    end

endmodule

// File: tb/tb_wide_split.sv
// Directed bench for wide_split: reset, drains, sparse lanes, underflow,
// backpressure with simultaneous push/pop, and reset mid-operation.
module tb_wide_split;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] i_data;
    logic        i_vld;
    logic        o_rdy;
    logic [3:0]  i_rd_strobe;
    logic [31:0] o_data;
    logic [3:0]  o_strobe;
    logic        o_vld;
    logic [4:0]  o_cnt;

    int errors = 0;
    int checks = 0;

    wide_split #(.DEPTH_BYTES(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_vld(i_vld), .o_rdy(o_rdy),
        .i_rd_strobe(i_rd_strobe), .o_data(o_data), .o_strobe(o_strobe),
        .o_vld(o_vld), .o_cnt(o_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_vld = 1'b1; i_data = 64'hFFEE_DDCC_BBAA_9988; i_rd_strobe = 4'hF;
        repeat (3) tick();
        checks++;
        if ({o_data, o_strobe, o_vld, o_rdy, o_cnt} !== {32'h0, 4'h0, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_hold: got data=%h strb=%b vld=%b rdy=%b cnt=%0d, want 0/0000/0/0/0",
                     o_data, o_strobe, o_vld, o_rdy, o_cnt);
        end
        rst_n = 1'b1; i_vld = 1'b0; i_rd_strobe = 4'h0;
        tick();
        checks++;
        if ({o_rdy, o_cnt, o_vld} !== {1'b1, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b cnt=%0d vld=%b, want 1/0/0", o_rdy, o_cnt, o_vld);
        end
    endtask

    task automatic test_full_drain();
        i_vld = 1'b1; i_data = 64'h0011_2233_4455_6677; i_rd_strobe = 4'h0;
        tick();
        checks++;
        if (o_cnt !== 5'd8) begin
            errors++; $display("FAIL drain_push: got cnt=%0d, want 8", o_cnt);
        end
        i_vld = 1'b0; i_rd_strobe = 4'hF;
        tick();
        checks++;
        if ({o_data, o_strobe, o_vld, o_cnt} !== {32'h0011_2233, 4'hF, 1'b1, 5'd4}) begin
            errors++;
            $display("FAIL drain_beat0: got %h/%b/%b/%0d, want 00112233/1111/1/4", o_data, o_strobe, o_vld, o_cnt);
        end
        tick();
        checks++;
        if ({o_data, o_strobe, o_vld, o_cnt} !== {32'h4455_6677, 4'hF, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL drain_beat1: got %h/%b/%b/%0d, want 44556677/1111/1/0", o_data, o_strobe, o_vld, o_cnt);
        end
    endtask

    task automatic test_sparse();
        logic [3:0]  req  [3] = '{4'b0101, 4'b1010, 4'b0110};
        logic [31:0] exp  [3] = '{32'h00A0_00A1, 32'hA200_A300, 32'h00A4_A500};
        logic [4:0]  ecnt [3] = '{5'd6, 5'd4, 5'd2};
        i_vld = 1'b1; i_data = 64'hA0A1_A2A3_A4A5_A6A7; i_rd_strobe = 4'h0;
        tick();
        i_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_rd_strobe = req[i];
            tick();
            checks++;
            if ({o_data, o_strobe, o_vld, o_cnt} !== {exp[i], req[i], 1'b1, ecnt[i]}) begin
                errors++;
                $display("FAIL sparse_%0d: got %h/%b/%b/%0d, want %h/%b/1/%0d",
                         i, o_data, o_strobe, o_vld, o_cnt, exp[i], req[i], ecnt[i]);
            end
        end
    endtask

    // Continues from the 2 bytes (A6, A7) left by the sparse test.
    task automatic test_underflow();
        i_rd_strobe = 4'hF;
        tick();
        checks++;
        if ({o_data, o_strobe, o_vld, o_cnt} !== {32'hA6A7_0000, 4'b1100, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL underflow_partial: got %h/%b/%b/%0d, want a6a70000/1100/1/0", o_data, o_strobe, o_vld, o_cnt);
        end
        tick();
        checks++;
        if ({o_data, o_strobe, o_vld, o_cnt} !== {32'h0, 4'h0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL underflow_empty: got %h/%b/%b/%0d, want 0/0000/0/0", o_data, o_strobe, o_vld, o_cnt);
        end
        i_rd_strobe = 4'h0;
        tick();
        checks++;
        if ({o_strobe, o_vld, o_data} !== {4'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL zero_strobe: got %b/%b/%h, want 0000/0/0", o_strobe, o_vld, o_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [6] = '{32'h1011_1213, 32'h1415_1617, 32'h2021_2223,
                                 32'h2425_2627, 32'h3031_3233, 32'h3435_3637};
        logic [4:0]  ecnt [6] = '{5'd12, 5'd8, 5'd12, 5'd8, 5'd4, 5'd0};
        logic        erdy [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        i_rd_strobe = 4'h0; i_vld = 1'b1;
        i_data = 64'h1011_1213_1415_1617; tick();
        i_data = 64'h2021_2223_2425_2627; tick();
        checks++;
        if ({o_cnt, o_rdy} !== {5'd16, 1'b0}) begin
            errors++; $display("FAIL full: got cnt=%0d rdy=%b, want 16/0", o_cnt, o_rdy);
        end
        // W3 is held on the input; it may only be taken once cnt falls to 8.
        i_data = 64'h3031_3233_3435_3637; i_rd_strobe = 4'hF;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) i_vld = 1'b0;
            tick();
            checks++;
            if ({o_data, o_strobe, o_cnt, o_rdy} !== {exp[i], 4'hF, ecnt[i], erdy[i]}) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h/%b/%0d/%b, want %h/1111/%0d/%b",
                         i, o_data, o_strobe, o_cnt, o_rdy, exp[i], ecnt[i], erdy[i]);
            end
        end
        i_rd_strobe = 4'h0;
    endtask

    task automatic test_reset_mid();
        i_rd_strobe = 4'h0; i_vld = 1'b1;
        i_data = 64'h5051_5253_5455_5657; tick();
        i_data = 64'h6061_6263_6465_6667; i_rd_strobe = 4'hF; tick();
        checks++;
        if (o_cnt !== 5'd12) begin
            errors++; $display("FAIL mid_setup: got cnt=%0d, want 12", o_cnt);
        end
        rst_n = 1'b0; i_data = 64'h7071_7273_7475_7677;
        #3;
        checks++;
        if (o_rdy !== 1'b0) begin
            errors++; $display("FAIL mid_rdy_low: got rdy=%b, want 0", o_rdy);
        end
        tick();
        checks++;
        if ({o_cnt, o_vld, o_strobe, o_data} !== {5'd0, 1'b0, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset: got cnt=%0d vld=%b strb=%b data=%h, want 0/0/0000/0", o_cnt, o_vld, o_strobe, o_data);
        end
        rst_n = 1'b1; i_vld = 1'b1; i_rd_strobe = 4'h0; i_data = 64'hC0C1_C2C3_C4C5_C6C7;
        tick();
        i_vld = 1'b0; i_rd_strobe = 4'hF;
        tick();
        checks++;
        if ({o_data, o_strobe, o_cnt} !== {32'hC0C1_C2C3, 4'hF, 5'd4}) begin
            errors++;
            $display("FAIL mid_after: got %h/%b/%0d, want c0c1c2c3/1111/4", o_data, o_strobe, o_cnt);
        end
        i_rd_strobe = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0; i_vld = 1'b0; i_data = '0; i_rd_strobe = '0;
        test_reset();
        test_full_drain();
        test_sparse();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
